// File: rtl/lsu_controller_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the funct3 encodings, the LSU state enum and the base byte-enable patterns.
package lsu_controller_pkg;

    localparam int REGISTER_WIDTH = 32;
    localparam int BYTE_WIDTH     = 8;

    typedef enum logic [2:0] {
        LOAD_LB  = 3'b000,
        LOAD_LH  = 3'b001,
        LOAD_LW  = 3'b010,
        LOAD_LBU = 3'b100,
        LOAD_LHU = 3'b101
    } FUNC3_LOAD;

    typedef enum logic [2:0] {
        STORE_SB = 3'b000,
        STORE_SH = 3'b001,
        STORE_SW = 3'b010
    } STypeFunct3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RDATA,
        RESP
    } lsu_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational datapath for the LSU: byte enables, store-lane replication,
// load extraction/extension and misaligned/illegal-funct3 detection.
module lsu_data_align
    import lsu_controller_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [31:0] lane;

    assign lane = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        be_o         = '0;
        wdata_o      = '0;
        rdata_o      = '0;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        if (is_store_i) begin
            case (funct3_i)
                STORE_SB: begin
                    be_o    = BE_BYTE << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                STORE_SH: begin
                    be_o         = BE_HALF << addr_lo_i;
                    wdata_o      = {2{wdata_i[15:0]}};
                    misaligned_o = addr_lo_i[0];
                end
                STORE_SW: begin
                    be_o         = BE_WORD;
                    wdata_o      = wdata_i;
                    misaligned_o = |addr_lo_i;
                end
                default: illegal_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                LOAD_LB: begin
                    be_o    = BE_BYTE << addr_lo_i;
                    rdata_o = {{24{lane[7]}}, lane[7:0]};
                end
                LOAD_LBU: begin
                    be_o    = BE_BYTE << addr_lo_i;
                    rdata_o = {24'h0, lane[7:0]};
                end
                LOAD_LH: begin
                    be_o         = BE_HALF << addr_lo_i;
                    rdata_o      = {{16{lane[15]}}, lane[15:0]};
                    misaligned_o = addr_lo_i[0];
                end
                LOAD_LHU: begin
                    be_o         = BE_HALF << addr_lo_i;
                    rdata_o      = {16'h0, lane[15:0]};
                    misaligned_o = addr_lo_i[0];
                end
                LOAD_LW: begin
                    be_o         = BE_WORD;
                    rdata_o      = lane;
                    misaligned_o = |addr_lo_i;
                end
                default: illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer: accepts one op at a time, runs a req/gnt/rvalid bus
// transaction and returns a single response with aligned, extended load data.
module lsu_controller
    import lsu_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = REGISTER_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_is_store_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [4:0]            req_rd_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [4:0]            rsp_rd_o,
    output logic                  rsp_error_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_t            state_q, state_d;
    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [4:0]            rd_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  accept;
    logic                  sel_is_store;
    logic [2:0]            sel_funct3;
    logic [1:0]            sel_addr_lo;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [3:0]            al_be;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [DATA_WIDTH-1:0] al_rdata;
    logic                  al_misaligned;
    logic                  al_illegal;

    assign accept = (state_q == IDLE) && req_valid_i;

    // In IDLE the aligner classifies the incoming op; afterwards it works on the captured op.
    assign sel_is_store = (state_q == IDLE) ? req_is_store_i     : is_store_q;
    assign sel_funct3   = (state_q == IDLE) ? req_funct3_i       : funct3_q;
    assign sel_addr_lo  = (state_q == IDLE) ? req_addr_i[1:0]    : addr_q[1:0];
    assign sel_wdata    = (state_q == IDLE) ? req_wdata_i        : wdata_q;

    lsu_data_align u_align (
        .is_store_i   (sel_is_store),
        .funct3_i     (sel_funct3),
        .addr_lo_i    (sel_addr_lo),
        .wdata_i      (sel_wdata),
        .rdata_i      (mem_rdata_i),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_misaligned),
        .illegal_o    (al_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = (al_misaligned || al_illegal) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_gnt_i) begin
                    state_d = is_store_q ? RESP : WAIT_RDATA;
                end
            end
            WAIT_RDATA: begin
                if (mem_rvalid_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Load data is cleared on accept so stores and error responses return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else if (accept) begin
            is_store_q <= req_is_store_i;
            funct3_q   <= req_funct3_i;
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
            rd_q       <= req_rd_i;
            rdata_q    <= '0;
            err_q      <= al_misaligned || al_illegal;
        end else if ((state_q == WAIT_RDATA) && mem_rvalid_i) begin
            rdata_q    <= al_rdata;
        end
    end

    assign req_ready_o = (state_q == IDLE);

    assign mem_req_o   = (state_q == ISSUE);
    assign mem_we_o    = (state_q == ISSUE) && is_store_q;
    assign mem_addr_o  = (state_q == ISSUE) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_be_o    = (state_q == ISSUE) ? al_be : '0;
    assign mem_wdata_o = ((state_q == ISSUE) && is_store_q) ? al_wdata : '0;

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = (state_q == RESP) ? rdata_q : '0;
    assign rsp_rd_o    = ((state_q == RESP) && !is_store_q) ? rd_q : '0;
    assign rsp_error_o = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller with a transaction-level reference model
// and a per-cycle compare process on bus and response outputs.
module tb_lsu_controller;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_is_store_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_error_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int tests;
    int failures;

    // Reference op currently in flight.
    logic        modelActive;
    logic        expStore;
    logic [2:0]  expF3;
    logic [31:0] expAddr;
    logic [31:0] expWdataIn;
    logic [4:0]  expRd;
    logic [31:0] expRdataIn;

    // Values captured from the DUT during the last runOp.
    int          lat;
    int          reqSeen;
    int          rspCycles;
    logic [31:0] capAddr;
    logic [3:0]  capBe;
    logic        capWe;
    logic [31:0] capWdata;
    logic [31:0] capRdata;
    logic [4:0]  capRd;
    logic        capErr;

    lsu_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_is_store_i (req_is_store_i),
        .req_funct3_i   (req_funct3_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_rd_i       (req_rd_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_rd_o       (rsp_rd_o),
        .rsp_error_o    (rsp_error_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int accessBytes();
        return 1 << expF3[1:0];
    endfunction

    function automatic logic modelErr();
        logic illegal;
        if (expStore) illegal = (expF3 >= 3);
        else          illegal = (expF3 == 3) || (expF3 == 6) || (expF3 == 7);
        if (illegal) return 1'b1;
        return (expAddr % accessBytes()) != 0;
    endfunction

    function automatic logic [3:0] modelBe();
        int mask;
        mask = (1 << accessBytes()) - 1;
        mask = mask << (expAddr % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] modelWdata();
        if (expF3 == 0) return (expWdataIn & 32'hFF) * 32'h0101_0101;
        if (expF3 == 1) return (expWdataIn & 32'hFFFF) * 32'h0001_0001;
        return expWdataIn;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * (expAddr % 4));
        case (expF3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFF_FF00; end
            3'd4: v = v & 32'hFF;
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF_0000; end
            3'd5: v = v & 32'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    // Compare DUT against the model on every cycle where a bus request or response is visible.
    always @(negedge clk) begin
        if (rst_n && modelActive) begin
            if (mem_req_o) begin
                checkOutput("mem_req_allowed", {31'h0, mem_req_o}, {31'h0, !modelErr()});
                checkOutput("mem_addr", mem_addr_o, expAddr & 32'hFFFF_FFFC);
                checkOutput("mem_we", {31'h0, mem_we_o}, {31'h0, expStore});
                checkOutput("mem_be", {28'h0, mem_be_o}, {28'h0, modelBe()});
                if (expStore) checkOutput("mem_wdata", mem_wdata_o, modelWdata());
            end
            if (rsp_valid_o) begin
                checkOutput("rsp_error", {31'h0, rsp_error_o}, {31'h0, modelErr()});
                checkOutput("rsp_rdata", rsp_rdata_o,
                            (modelErr() || expStore) ? 32'h0 : modelLoad(expRdataIn));
                checkOutput("rsp_rd", {27'h0, rsp_rd_o}, expStore ? 32'h0 : {27'h0, expRd});
            end
        end
    end

    // Issue one op and play a simple memory: grant after gntDelay request cycles,
    // return read data the cycle after grant, hold rsp_ready low for rspDelay cycles.
    task automatic applyStimulus(input logic isStore, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                                 input int gntDelay, input int rspDelay, input logic spurious);
        logic rvPending;
        logic done;
        int   held;
        expStore = isStore; expF3 = f3; expAddr = addr;
        expWdataIn = wdata; expRd = rd; expRdataIn = rdata;
        modelActive = 1'b1;
        req_is_store_i = isStore; req_funct3_i = f3; req_addr_i = addr;
        req_wdata_i = wdata; req_rd_i = rd; req_valid_i = 1'b1;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (req_ready_o) break;
        end
        lat = -1; reqSeen = 0; rspCycles = 0; held = 0; rvPending = 1'b0; done = 1'b0;
        capAddr = '0; capBe = '0; capWe = 1'b0; capWdata = '0;
        capRdata = 32'hFFFF_FFFF; capRd = '1; capErr = 1'b1;
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            req_valid_i = 1'b0;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; rsp_ready_i = 1'b0;
            mem_rdata_i = 32'h0;
            if (rvPending) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = rdata; rvPending = 1'b0;
            end
            if (mem_req_o) begin
                if (reqSeen == 0) begin
                    capAddr = mem_addr_o; capBe = mem_be_o; capWe = mem_we_o; capWdata = mem_wdata_o;
                end
                reqSeen++;
                if (reqSeen > gntDelay) begin
                    mem_gnt_i = 1'b1;
                    if (!isStore) rvPending = 1'b1;
                end else if (spurious) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A_5A5A;
                end
            end
            if (lat >= 0) checkOutput("rsp_held", {31'h0, rsp_valid_o}, 32'h1);
            if (rsp_valid_o) begin
                rspCycles++;
                if (lat < 0) begin
                    lat = c; capRdata = rsp_rdata_o; capRd = rsp_rd_o; capErr = rsp_error_o;
                end
                if (held < rspDelay) held++;
                else begin rsp_ready_i = 1'b1; done = 1'b1; end
            end
        end
        checkOutput("op_completed", {31'h0, done}, 32'h1);
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        modelActive = 1'b0;
    endtask

    initial begin
        tests = 0; failures = 0; modelActive = 1'b0;
        rst_n = 1'b0; req_valid_i = 1'b0; req_is_store_i = 1'b0; req_funct3_i = '0;
        req_addr_i = '0; req_wdata_i = '0; req_rd_i = '0; rsp_ready_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        expStore = 1'b0; expF3 = '0; expAddr = '0; expWdataIn = '0; expRd = '0; expRdataIn = '0;
        #12;
        checkOutput("reset_req_ready", {31'h0, req_ready_o}, 32'h1);
        checkOutput("reset_mem_req", {31'h0, mem_req_o}, 32'h0);
        checkOutput("reset_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        checkOutput("reset_mem_addr", mem_addr_o, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 5'd3, 32'h0, 0, 0, 1'b0);
        checkOutput("sw_latency", lat, 2);
        checkOutput("sw_addr", capAddr, 32'h100);
        checkOutput("sw_be", {28'h0, capBe}, 32'hF);
        checkOutput("sw_we", {31'h0, capWe}, 32'h1);
        checkOutput("sw_wdata", capWdata, 32'hDEAD_BEEF);
        checkOutput("sw_err", {31'h0, capErr}, 32'h0);
        checkOutput("sw_rd", {27'h0, capRd}, 32'h0);

        applyStimulus(1'b1, 3'd0, 32'h103, 32'h0000_00A5, 5'd0, 32'h0, 0, 0, 1'b0);
        checkOutput("sb_addr", capAddr, 32'h100);
        checkOutput("sb_be", {28'h0, capBe}, 32'h8);
        checkOutput("sb_wdata", capWdata, 32'hA5A5_A5A5);

        applyStimulus(1'b1, 3'd1, 32'h202, 32'h1234_CAFE, 5'd0, 32'h0, 0, 0, 1'b0);
        checkOutput("sh_be", {28'h0, capBe}, 32'hC);
        checkOutput("sh_wdata", capWdata, 32'hCAFE_CAFE);

        applyStimulus(1'b0, 3'd0, 32'h101, 32'h0, 5'd7, 32'h1234_8001, 0, 0, 1'b0);
        checkOutput("lb_latency", lat, 3);
        checkOutput("lb_rdata", capRdata, 32'hFFFF_FF80);
        checkOutput("lb_rd", {27'h0, capRd}, 32'h7);
        checkOutput("lb_be", {28'h0, capBe}, 32'h2);
        applyStimulus(1'b0, 3'd4, 32'h101, 32'h0, 5'd8, 32'h1234_8001, 0, 0, 1'b0);
        checkOutput("lbu_rdata", capRdata, 32'h0000_0080);

        applyStimulus(1'b0, 3'd1, 32'h102, 32'h0, 5'd9, 32'hBEEF_0000, 0, 0, 1'b0);
        checkOutput("lh_rdata", capRdata, 32'hFFFF_BEEF);
        applyStimulus(1'b0, 3'd5, 32'h102, 32'h0, 5'd10, 32'hBEEF_0000, 0, 0, 1'b0);
        checkOutput("lhu_rdata", capRdata, 32'h0000_BEEF);
        applyStimulus(1'b0, 3'd2, 32'h104, 32'h0, 5'd11, 32'h1357_2468, 0, 0, 1'b0);
        checkOutput("lw_rdata", capRdata, 32'h1357_2468);

        applyStimulus(1'b0, 3'd2, 32'h102, 32'h0, 5'd12, 32'hFFFF_FFFF, 0, 0, 1'b0);
        checkOutput("lw_mis_err", {31'h0, capErr}, 32'h1);
        checkOutput("lw_mis_rdata", capRdata, 32'h0);
        checkOutput("lw_mis_noreq", reqSeen, 0);
        checkOutput("lw_mis_latency", lat, 1);
        applyStimulus(1'b0, 3'd3, 32'h100, 32'h0, 5'd13, 32'hFFFF_FFFF, 0, 0, 1'b0);
        checkOutput("ld_f3_3_err", {31'h0, capErr}, 32'h1);
        checkOutput("ld_f3_3_noreq", reqSeen, 0);
        applyStimulus(1'b1, 3'd3, 32'h100, 32'h1, 5'd0, 32'h0, 0, 0, 1'b0);
        checkOutput("st_f3_3_err", {31'h0, capErr}, 32'h1);
        applyStimulus(1'b1, 3'd1, 32'h101, 32'h1, 5'd0, 32'h0, 0, 0, 1'b0);
        checkOutput("sh_mis_err", {31'h0, capErr}, 32'h1);

        applyStimulus(1'b0, 3'd2, 32'h200, 32'h0, 5'd14, 32'hA1B2_C3D4, 3, 2, 1'b1);
        checkOutput("slow_req_cycles", reqSeen, 4);
        checkOutput("slow_latency", lat, 6);
        checkOutput("slow_rsp_cycles", rspCycles, 3);
        checkOutput("slow_rdata", capRdata, 32'hA1B2_C3D4);

        // Reset while a load waits for its read data.
        req_is_store_i = 1'b0; req_funct3_i = 3'd2; req_addr_i = 32'h300; req_rd_i = 5'd15;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("rst_issue_req", {31'h0, mem_req_o}, 32'h1);
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        checkOutput("rst_wait_noreq", {31'h0, mem_req_o}, 32'h0);
        checkOutput("rst_wait_ready", {31'h0, req_ready_o}, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", {31'h0, req_ready_o}, 32'h1);
        checkOutput("midrst_mem_req", {31'h0, mem_req_o}, 32'h0);
        checkOutput("midrst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("late_rvalid_rsp", {31'h0, rsp_valid_o}, 32'h0);
            checkOutput("late_rvalid_ready", {31'h0, req_ready_o}, 32'h1);
        end

        applyStimulus(1'b0, 3'd0, 32'h003, 32'h0, 5'd16, 32'h7F00_0000, 0, 0, 1'b0);
        checkOutput("post_rst_lb", capRdata, 32'h0000_007F);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
